user_proj_mtimer: RTL
=====================

USER_PROJ_MTIMER -- requirements
Module: user_proj_mtimer

Interface
REQ-001 SHALL have parameter NCH, default 4: channel count, 1..8.
REQ-002 SHALL have parameter CW, default 16: counter width, minimum 4.
REQ-003 SHALL have parameter PW, default 8: prescaler width.
REQ-004 SHALL have port wb_clk_i  in  1  clock; one clock; all state on its rising edge.
REQ-005 SHALL have port wb_rst_i  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port cfg_we  in  1  register write strobe, one cycle per write.
REQ-007 SHALL have port cfg_ch  in  max(1,$clog2(NCH))  target channel; also the readback channel.
REQ-008 SHALL have port cfg_sel  in  2  register select: 0 PERIOD, 1 COMPARE, 2 CTRL, 3 PRESCALE (global).
REQ-009 SHALL have port cfg_wdata  in  CW  write data.
REQ-010 SHALL have port cnt_rd  out  CW  counter of channel cfg_ch, combinational mux.
REQ-011 SHALL have port tmr_out  out  NCH  per-channel timer output, registered.
REQ-012 SHALL have port tmr_oeb  out  NCH  output enable, active-low; 0 while the channel is enabled.
REQ-013 SHALL have port tmr_irq  out  NCH  sticky terminal-count flags.

Function
REQ-014 SHALL raise tick for one cycle every PSC+1 clocks; PSC=0 gives tick every cycle. A PRESCALE write reloads the divider to 0.
REQ-015 SHALL decode CTRL write data as: bits[1:0] mode (00 one-shot, 01 periodic, 10 PWM, 11 treated as periodic), bit[2] en, bit[3] irq_clr.
REQ-016 SHALL clear the channel counter to 0 and tmr_out to 0 on the edge of a CTRL write that moves en from 0 to 1.
REQ-017 SHALL increment an enabled channel counter by 1 on tick.
REQ-018 SHALL treat tick with cnt>=PERIOD as terminal: the counter wraps to 0 and tmr_irq is set on the same edge. Because the test is >=, a PERIOD lowered below cnt wraps on the next tick; PERIOD=0 gives a terminal event on every tick.
REQ-019 SHALL toggle tmr_out on each terminal edge in periodic mode.
REQ-020 SHALL, in one-shot mode, on the terminal edge set tmr_out=1, clear en and hold the counter at 0.
REQ-021 SHALL, in PWM mode, drive tmr_out = (cnt < COMPARE) registered: COMPARE=0 gives constant 0; COMPARE>PERIOD gives constant 1.
REQ-022 SHALL apply PERIOD and COMPARE writes from the next edge, without resetting the counter.
REQ-023 SHALL clear tmr_irq on a CTRL write with irq_clr=1. If a terminal event occurs in the same cycle, set wins.
REQ-024 SHALL freeze the counter and tmr_out when en=0; tmr_irq is retained.
REQ-025 SHALL keep channels independent; a write to one channel never alters another.

Reset
REQ-026 SHALL clear on wb_rst_i: all counters, PERIOD, COMPARE, CTRL and PSC to 0; tmr_out=0; tmr_irq=0; tmr_oeb=all 1s.
REQ-027 SHALL let reset override any simultaneous cfg_we; the write is lost.

Configuration
REQ-028 SHALL, with MTIMER_CAPTURE_EN defined, add port cap_in (in, NCH) and port cap_rd (out, CW). Each cap_in bit is 2-flop synchronised; its rising edge latches that channel's counter into a capture register. cap_rd shows the capture register of cfg_ch. Capture registers reset to 0.
REQ-029 SHALL, without MTIMER_CAPTURE_EN, omit cap_in, cap_rd, the synchronisers and the capture registers.

Structure
REQ-030 SHALL place the mode encodings, cfg_sel constants and CTRL bit positions in package mtimer_pkg.
REQ-031 SHALL implement one channel as sub-module mtimer_ch, instantiated NCH times. The prescaler and write decode stay in the top.

Verification
REQ-032 SHALL cover: PSC=0, PERIOD=3, periodic, en -> tmr_out toggles every 4 cycles; tmr_irq set on first wrap, 4 cycles after enable.
REQ-033 SHALL cover: PSC=1, PERIOD=2, one-shot -> tmr_irq and tmr_out go to 1 at cycle 6; en reads 0 afterwards; counter stays 0.
REQ-034 SHALL cover: PWM, PERIOD=9, COMPARE=3 -> 30% duty; COMPARE=0 -> constant 0; COMPARE=12 -> constant 1.
REQ-035 SHALL cover: irq_clr written on the exact terminal cycle -> tmr_irq remains 1.
REQ-036 SHALL cover: PERIOD lowered from 100 to 5 while cnt=50 -> wrap on the next tick; other channels unaffected.
REQ-037 SHALL cover: wb_rst_i asserted mid-count, with cfg_we high in the same cycle -> all outputs return to reset values; the write is ignored.

Source files
------------

// File: rtl/mtimer_pkg.sv
// Shared encodings for the multi-channel timer: channel modes, register selects
// and the bit layout of the per-channel CTRL word.
package mtimer_pkg;

  typedef enum logic [1:0] {
    MODE_ONESHOT      = 2'b00,
    MODE_PERIODIC     = 2'b01,
    MODE_PWM          = 2'b10,
    MODE_PERIODIC_ALT = 2'b11
  } mode_e;

  localparam logic [1:0] SEL_PERIOD   = 2'd0;
  localparam logic [1:0] SEL_COMPARE  = 2'd1;
  localparam logic [1:0] SEL_CTRL     = 2'd2;
  localparam logic [1:0] SEL_PRESCALE = 2'd3;

  localparam int CTRL_MODE_LSB    = 0;
  localparam int CTRL_MODE_MSB    = 1;
  localparam int CTRL_EN_BIT      = 2;
  localparam int CTRL_IRQ_CLR_BIT = 3;

endpackage

// File: rtl/mtimer_ch.sv
// One timer channel: PERIOD/COMPARE/CTRL registers, counter, output and sticky
// terminal-count flag. Advances only on the shared prescaler tick.
module mtimer_ch
  import mtimer_pkg::*;
#(
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick,
  input  logic          we_period,
  input  logic          we_compare,
  input  logic          we_ctrl,
  input  logic [CW-1:0] wdata,
  output logic [CW-1:0] cnt,
  output logic          tmr_out,
  output logic          en,
  output logic          irq
);

  logic [CW-1:0] period;
  logic [CW-1:0] compare;
  mode_e         mode;
  mode_e         ctrl_mode;
  logic          ctrl_en;
  logic          ctrl_clr;
  logic          start;
  logic          terminal;

  always_comb begin
    ctrl_mode = mode_e'(wdata[CTRL_MODE_MSB:CTRL_MODE_LSB]);
    ctrl_en   = wdata[CTRL_EN_BIT];
    ctrl_clr  = wdata[CTRL_IRQ_CLR_BIT];
    start     = we_ctrl && ctrl_en && !en;
    // >= so that a PERIOD lowered below the running count still wraps promptly
    terminal  = en && tick && (cnt >= period);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      period  <= '0;
      compare <= '0;
      mode    <= MODE_ONESHOT;
      en      <= 1'b0;
      cnt     <= '0;
      tmr_out <= 1'b0;
      irq     <= 1'b0;
    end else begin
      if (we_period)  period  <= wdata;
      if (we_compare) compare <= wdata;
      if (we_ctrl) begin
        mode <= ctrl_mode;
        en   <= ctrl_en;
      end

      if (terminal)                irq <= 1'b1;
      else if (we_ctrl && ctrl_clr) irq <= 1'b0;

      if (start) begin
        cnt     <= '0;
        tmr_out <= 1'b0;
      end else if (en) begin
        if (terminal)  cnt <= '0;
        else if (tick) cnt <= cnt + 1'b1;

        case (mode)
          MODE_PWM: tmr_out <= (cnt < compare);
          MODE_ONESHOT: begin
            // a one-shot disarms itself; this overrides a same-cycle CTRL en
            if (terminal) begin
              tmr_out <= 1'b1;
              en      <= 1'b0;
            end
          end
          default: if (terminal) tmr_out <= ~tmr_out;
        endcase
      end
    end
  end

endmodule

// File: rtl/user_proj_mtimer.sv
// Multi-channel timer top: global prescaler, register write decode and readback mux.
// Optional input-capture path enabled by defining MTIMER_CAPTURE_EN.
module user_proj_mtimer
  import mtimer_pkg::*;
#(
  parameter  int NCH = 4,
  parameter  int CW  = 16,
  parameter  int PW  = 8,
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           wb_clk_i,
  input  logic           wb_rst_i,
  input  logic           cfg_we,
  input  logic [CHW-1:0] cfg_ch,
  input  logic [1:0]     cfg_sel,
  input  logic [CW-1:0]  cfg_wdata,
  output logic [CW-1:0]  cnt_rd,
  output logic [NCH-1:0] tmr_out,
  output logic [NCH-1:0] tmr_oeb,
  output logic [NCH-1:0] tmr_irq
`ifdef MTIMER_CAPTURE_EN
  ,
  input  logic [NCH-1:0] cap_in,
  output logic [CW-1:0]  cap_rd
`endif
);

  logic [PW-1:0]  psc;
  logic [PW-1:0]  div;
  logic           tick;
  logic           psc_we;
  logic [NCH-1:0] en_vec;
  logic [CW-1:0]  cnt_arr [NCH];

  assign tick    = (div == psc);
  assign psc_we  = cfg_we && (cfg_sel == SEL_PRESCALE);
  assign tmr_oeb = ~en_vec;

  // A PRESCALE write restarts the divider so the new rate takes a known phase
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      psc <= '0;
      div <= '0;
    end else if (psc_we) begin
      psc <= PW'(cfg_wdata);
      div <= '0;
    end else if (tick) begin
      div <= '0;
    end else begin
      div <= div + 1'b1;
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic hit;
    assign hit = cfg_we && (cfg_ch == CHW'(i));

    mtimer_ch #(.CW(CW)) u_ch (
      .clk        (wb_clk_i),
      .rst        (wb_rst_i),
      .tick       (tick),
      .we_period  (hit && (cfg_sel == SEL_PERIOD)),
      .we_compare (hit && (cfg_sel == SEL_COMPARE)),
      .we_ctrl    (hit && (cfg_sel == SEL_CTRL)),
      .wdata      (cfg_wdata),
      .cnt        (cnt_arr[i]),
      .tmr_out    (tmr_out[i]),
      .en         (en_vec[i]),
      .irq        (tmr_irq[i])
    );
  end

  always_comb begin
    cnt_rd = '0;
    for (int i = 0; i < NCH; i++) begin
      if (cfg_ch == CHW'(i)) cnt_rd = cnt_arr[i];
    end
  end

`ifdef MTIMER_CAPTURE_EN
  logic [NCH-1:0] cap_s1;
  logic [NCH-1:0] cap_s2;
  logic [NCH-1:0] cap_s3;
  logic [CW-1:0]  cap_reg [NCH];

  // Two synchroniser stages, the third flop only serves rising-edge detection
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      cap_s1 <= '0;
      cap_s2 <= '0;
      cap_s3 <= '0;
      for (int i = 0; i < NCH; i++) cap_reg[i] <= '0;
    end else begin
      cap_s1 <= cap_in;
      cap_s2 <= cap_s1;
      cap_s3 <= cap_s2;
      for (int i = 0; i < NCH; i++) begin
        if (cap_s2[i] && !cap_s3[i]) cap_reg[i] <= cnt_arr[i];
      end
    end
  end

  always_comb begin
    cap_rd = '0;
    for (int i = 0; i < NCH; i++) begin
      if (cfg_ch == CHW'(i)) cap_rd = cap_reg[i];
    end
  end
`else
  // Without the capture path the counters are observable only through cnt_rd
`endif

endmodule
